// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one shared modular multiplier.
// Optional macro CONST_TIME_EN: issue a multiply for every exponent bit (timing independent of exp).
module rsa_modexp_ctrl #(
  parameter int WIDTH = 16,
  parameter int EXP_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [EXP_W-1:0] exp,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             finish,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic [7:0]       mul_count,
  output logic             mul_start,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  output logic [WIDTH-1:0] mul_n,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_p
);

  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SQR_REQ, S_SQR_WAIT, S_MUL_REQ, S_MUL_WAIT, S_NEXT, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   base_q, base_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [WIDTH-1:0]   n_q, n_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               busy_q, busy_d;
  logic               fin_q, fin_d;
`ifdef CONST_TIME_EN
  logic [WIDTH-1:0]   dummy_q, dummy_d;
`endif

  logic [7:0] cnt_inc;
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      exp_q   <= '0;
      n_q     <= '0;
      r_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
`ifdef CONST_TIME_EN
      dummy_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      n_q     <= n_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
`ifdef CONST_TIME_EN
      dummy_q <= dummy_d;
`endif
    end
  end

  // Operands are loaded on entry to a REQ state so they are stable for the whole request.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    exp_d   = exp_q;
    n_d     = n_q;
    r_d     = r_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    fin_d   = 1'b0;
`ifdef CONST_TIME_EN
    dummy_d = dummy_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d = base;
          exp_d  = exp;
          n_d    = modulus;
          idx_d  = IDX_W'(EXP_W - 1);
          cnt_d  = '0;
          busy_d = 1'b1;
          if (modulus == '0) begin
            r_d     = '0;
            state_d = S_DONE;
          end else begin
            r_d     = WIDTH'(1);
            a_d     = WIDTH'(1);
            b_d     = WIDTH'(1);
            state_d = S_SQR_REQ;
          end
        end
      end
      S_SQR_REQ: begin
        cnt_d   = cnt_inc;
        state_d = S_SQR_WAIT;
      end
      S_SQR_WAIT: begin
        if (mul_done) begin
          r_d = mul_p;
`ifdef CONST_TIME_EN
          a_d     = mul_p;
          b_d     = base_q;
          state_d = S_MUL_REQ;
`else
          if (exp_q[idx_q]) begin
            a_d     = mul_p;
            b_d     = base_q;
            state_d = S_MUL_REQ;
          end else begin
            state_d = S_NEXT;
          end
`endif
        end
      end
      S_MUL_REQ: begin
        cnt_d   = cnt_inc;
        state_d = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        if (mul_done) begin
`ifdef CONST_TIME_EN
          if (exp_q[idx_q]) r_d = mul_p;
          else              dummy_d = mul_p;
`else
          r_d = mul_p;
`endif
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (idx_q == '0) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q - 1'b1;
          a_d     = r_q;
          b_d     = r_q;
          state_d = S_SQR_REQ;
        end
      end
      S_DONE: begin
        res_d   = r_q;
        err_d   = (n_q == '0);
        fin_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign finish    = fin_q;
  assign result    = res_q;
  assign err       = err_q;
  assign mul_count = cnt_q;
  assign mul_start = (state_q == S_SQR_REQ) || (state_q == S_MUL_REQ);
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign mul_n     = n_q;

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Scoreboard bench for rsa_modexp_ctrl: a multiplier model with fixed or random latency,
// expected results from a right-to-left exponentiation reference. Honours CONST_TIME_EN.
module tb_rsa_modexp_ctrl;
  localparam int W  = 16;
  localparam int EW = 16;
  localparam int L  = 3;

  logic          clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [W-1:0]  base = '0, modulus = '0;
  logic [EW-1:0] exp = '0;
  logic          busy, finish, err, mul_start, mul_done;
  logic [W-1:0]  result, mul_a, mul_b, mul_n, mul_p;
  logic [7:0]    mul_count;
  logic          mdl_done = 1'b0, spur_done = 1'b0;
  logic [W-1:0]  mdl_p = '0;

  assign mul_done = mdl_done | spur_done;
  assign mul_p    = spur_done ? 16'h0BAD : mdl_p;

  rsa_modexp_ctrl #(.WIDTH(W), .EXP_W(EW)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .exp(exp), .modulus(modulus),
    .busy(busy), .finish(finish), .result(result), .err(err), .mul_count(mul_count),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_n(mul_n),
    .mul_done(mul_done), .mul_p(mul_p)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  bit lat_fixed = 1'b1;
  int rst_count = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           cnt;
    int           lat;
    int           t0;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_pow(input longint unsigned b, input longint unsigned e,
                                           input longint unsigned n);
    longint unsigned r, x;
    if (n == 0) return '0;
    r = 1 % n;
    x = b % n;
    while (e != 0) begin
      if (e[0]) r = (r * x) % n;
      x = (x * x) % n;
      e = e >> 1;
    end
    return W'(r);
  endfunction

  function automatic int ref_cnt(input logic [EW-1:0] e, input logic [W-1:0] n);
    if (n == 0) return 0;
`ifdef CONST_TIME_EN
    return 2 * EW;
`else
    return EW + $countones(e);
`endif
  endfunction

  function automatic int ref_lat(input logic [EW-1:0] e, input logic [W-1:0] n);
    if (n == 0) return 2;
`ifdef CONST_TIME_EN
    return 1 + EW * (2 * L + 3) + 1;
`else
    return 1 + EW * (L + 2) + $countones(e) * (L + 1) + 1;
`endif
  endfunction

  // multiplier model: mul_done exactly lat cycles after the mul_start cycle
  logic [W-1:0] m_a, m_b, m_n;
  int m_lat, m_rc;
  initial begin
    forever begin
      @(negedge clk);
      if (mul_start && !rst) begin
        m_a = mul_a; m_b = mul_b; m_n = mul_n; m_rc = rst_count;
        m_lat = lat_fixed ? L : int'($urandom_range(1, 5));
        repeat (m_lat - 1) @(negedge clk);
        @(posedge clk); #1;
        if (m_rc == rst_count) begin
          check("mul_a_stable", mul_a, m_a);
          check("mul_b_stable", mul_b, m_b);
          check("mul_n_stable", mul_n, m_n);
        end
        mdl_p = (m_n == 0) ? '0 : W'((64'(m_a) * 64'(m_b)) % 64'(m_n));
        mdl_done = 1'b1;
        @(posedge clk); #1;
        mdl_done = 1'b0;
      end
    end
  end

  // monitor: pops the scoreboard whenever finish is presented
  int pulses = 0;
  bit prev_fin = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) pulses = 0;
    else if (mul_start) pulses++;
    if (prev_fin) check("finish_width", finish, 0);
    if (finish) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_finish: got result %0d expected no finish", result);
      end else begin
        mon_e = sb.pop_front();
        check("result", result, mon_e.res);
        check("err", err, mon_e.err);
        check("mul_count", mul_count, mon_e.cnt);
        check("mul_start_pulses", pulses, mon_e.cnt);
        check("busy_at_finish", busy, 0);
        if (mon_e.lat >= 0) check("latency", cyc - mon_e.t0, mon_e.lat);
      end
      pulses = 0;
    end
    prev_fin = finish;
  end

  task automatic push_exp(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] n);
    exp_t x;
    x.res = ref_pow(b, e, n);
    x.err = (n == 0);
    x.cnt = ref_cnt(e, n);
    x.lat = (lat_fixed || n == 0) ? ref_lat(e, n) : -1;
    x.t0  = cyc;
    sb.push_back(x);
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (busy && i < 4000) begin
      @(negedge clk);
      i++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic do_op(input logic [W-1:0] b, input logic [EW-1:0] e, input logic [W-1:0] n);
    base = b; exp = e; modulus = n; start = 1'b1;
    push_exp(b, e, n);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_finish", finish, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    check("rst_mul_count", mul_count, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_mul_n", mul_n, 0);
  endtask

  initial begin
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    lat_fixed = 1'b1;
    do_op(16'd89, 16'd3, 16'd3127);
    do_op(16'd1394, 16'd2011, 16'd3127);
    do_op(16'd1394, 16'd2047, 16'd3127);
    do_op(16'd65, 16'd17, 16'd3233);
    do_op(16'd2790, 16'd2753, 16'd3233);
    do_op(16'd5, 16'd0, 16'd3127);
    do_op(16'd7, 16'd9, 16'd0);
    do_op(16'd0, 16'd12345, 16'd1);

    // start during busy and in the DONE cycle, spurious mul_done in NEXT: all ignored
    begin
      int t;
      t = ref_lat(16'd3, 16'd3127);
      base = 16'd89; exp = 16'd3; modulus = 16'd3127; start = 1'b1;
      push_exp(16'd89, 16'd3, 16'd3127);
      for (int c = 1; c < t; c++) begin
        @(negedge clk);
        start     = (c == 3) || (c == t - 1);
        spur_done = (c == 5);
        base = 16'h1234; exp = 16'hFFFF; modulus = 16'h00FF;
      end
      @(negedge clk);
      start = 1'b0;
      spur_done = 1'b0;
      repeat (5) @(negedge clk);
      check("start_in_done_ignored", busy, 0);
    end

    // reset in the middle of SQR_WAIT; the multiplier's late mul_done must be ignored
    base = 16'd89; exp = 16'd3; modulus = 16'd3127; start = 1'b1;
    push_exp(16'd89, 16'd3, 16'd3127);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    sb.delete();
    rst = 1'b1;
    rst_count++;
    #1;
    check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("late_done_ignored", busy, 0);
    do_op(16'd89, 16'd3, 16'd3127);

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] n, b;
      logic [EW-1:0] e;
      int k;
      lat_fixed = (i % 2) == 0;
      k = int'($urandom_range(0, 9));
      n = W'($urandom);
      if (k == 0) n = '0;
      if (k == 1) n = W'(1);
      b = (n == 0) ? W'($urandom) : W'($urandom % n);
      e = EW'($urandom);
      if (k == 2) e = '0;
      if (k == 3) e = '1;
      do_op(b, e, n);
    end

    repeat (10) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
